// File: rtl/invd_pipe_pkg.sv
// Shared definitions for the invd_pipe datapath.
// Operation mode encodings applied to each accepted word.
package invd_pipe_pkg;
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_PASS = 2'b00;
   localparam mode_t MODE_INV  = 2'b01;
   localparam mode_t MODE_XOR  = 2'b10;
   localparam mode_t MODE_XNOR = 2'b11;
endpackage

// File: rtl/invd_stage.sv
// One valid/data register slice of the invd_pipe pipeline.
// Loads from upstream whenever it is empty or its contents are being taken downstream.
module invd_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy_i,
   input  logic             up_valid_i,
   input  logic [WIDTH-1:0] up_data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             take;

   // Data only moves on a real load so a stalled or drained slice keeps its word stable.
   always_comb begin
      take    = ~valid_q | rdy_i;
      valid_d = valid_q;
      data_d  = data_q;
      if (take) begin
         valid_d = up_valid_i;
         if (up_valid_i) begin
            data_d = up_data_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/invd_pipe.sv
// Pipelined per-word pass/invert/XOR/XNOR unit with valid/ready on both sides.
// Holds the mask register, the function mux, the ready chain and the delivered-word counter.
module invd_pipe
   import invd_pipe_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   input  logic             mask_we,
   input  logic [WIDTH-1:0] mask_din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] word_cnt
);
   if (STAGES < 1) begin : g_bad_cfg
      $error("invd_pipe: STAGES must be >= 1");
   end

   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] f_res;
   logic [STAGES-1:0] v, rdy, up_v;
   logic [WIDTH-1:0]  sd   [STAGES];
   logic [WIDTH-1:0]  up_d [STAGES];

   // The mux sees the registered mask, so a same-cycle mask write only affects later words.
   always_comb begin
      case (in_mode)
         MODE_PASS: f_res = in_data;
         MODE_INV:  f_res = ~in_data;
         MODE_XOR:  f_res = in_data ^ mask_q;
         default:   f_res = ~(in_data ^ mask_q);
      endcase
   end

   always_comb begin
      rdy           = '0;
      rdy[STAGES-1] = out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         rdy[k] = ~v[k+1] | rdy[k+1];
      end
   end

   always_comb begin
      up_v    = '0;
      up_v[0] = in_valid;
      up_d[0] = f_res;
      for (int k = 1; k < STAGES; k++) begin
         up_v[k] = v[k-1];
         up_d[k] = sd[k-1];
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      invd_stage #(.WIDTH(WIDTH)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .rdy_i      (rdy[gi]),
         .up_valid_i (up_v[gi]),
         .up_data_i  (up_d[gi]),
         .valid_o    (v[gi]),
         .data_o     (sd[gi])
      );
   end

   assign in_ready  = rst_n & (~v[0] | rdy[0]);
   assign out_valid = v[STAGES-1];
   assign out_data  = sd[STAGES-1];
   assign word_cnt  = cnt_q;

   always_comb begin
      mask_d = mask_we ? mask_din : mask_q;
      cnt_d  = cnt_q;
      if (out_valid & out_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         cnt_q  <= '0;
      end else begin
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_invd_pipe.sv
// Self-checking bench for invd_pipe: three configurations, queue scoreboards on A and C,
// scenario tasks run in sequence from one initial block.
module tb_invd_pipe;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   // Instance A: WIDTH=8, STAGES=2, CNT_W=16
   logic        a_in_valid, a_in_ready, a_mask_we, a_out_valid, a_out_ready;
   logic [7:0]  a_in_data, a_mask_din, a_out_data;
   logic [1:0]  a_in_mode;
   logic [15:0] a_word_cnt;
   // Instance B: WIDTH=8, STAGES=2, CNT_W=4
   logic        b_in_valid, b_in_ready, b_mask_we, b_out_valid, b_out_ready;
   logic [7:0]  b_in_data, b_mask_din, b_out_data;
   logic [1:0]  b_in_mode;
   logic [3:0]  b_word_cnt;
   // Instance C: WIDTH=32, STAGES=1, CNT_W=16
   logic        c_in_valid, c_in_ready, c_mask_we, c_out_valid, c_out_ready;
   logic [31:0] c_in_data, c_mask_din, c_out_data;
   logic [1:0]  c_in_mode;
   logic [15:0] c_word_cnt;

   invd_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_mode(a_in_mode), .mask_we(a_mask_we), .mask_din(a_mask_din),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .word_cnt(a_word_cnt)
   );
   invd_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(b_in_mode), .mask_we(b_mask_we), .mask_din(b_mask_din),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .word_cnt(b_word_cnt)
   );
   invd_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(16)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_mode(c_in_mode), .mask_we(c_mask_we), .mask_din(c_mask_din),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .word_cnt(c_word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_f(input logic [1:0] m, input logic [31:0] a, input logic [31:0] k);
      case (m)
         2'b00:   return a;
         2'b01:   return ~a;
         2'b10:   return a ^ k;
         default: return ~(a ^ k);
      endcase
   endfunction

   // Scoreboards: push at input transfer, pop and compare at output transfer (sampled at negedge).
   logic [7:0]  q_a [$];
   logic [7:0]  mask_m_a;
   logic [7:0]  exp_a;
   logic [31:0] r_a;
   logic [31:0] q_c [$];
   logic [31:0] mask_m_c;
   logic [31:0] exp_c;
   int          cnt_m_c;

   always @(negedge clk) begin
      if (!rst_n) begin
         q_a.delete();
         mask_m_a = 8'h00;
      end else begin
         if (a_out_valid && a_out_ready) begin
            n_cmp++;
            if (q_a.size() == 0) begin
               n_bad++;
               $display("FAIL sb_a_unexpected: got %h, required no output", a_out_data);
            end else begin
               exp_a = q_a.pop_front();
               $display("a xfer: data=%h expected=%h", a_out_data, exp_a);
               if (a_out_data !== exp_a) begin
                  n_bad++;
                  $display("FAIL sb_a_data: got %h, required %h", a_out_data, exp_a);
               end
            end
         end
         if (a_in_valid && a_in_ready) begin
            r_a = ref_f(a_in_mode, {24'h0, a_in_data}, {24'h0, mask_m_a});
            q_a.push_back(r_a[7:0]);
         end
         if (a_mask_we) mask_m_a = a_mask_din;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q_c.delete();
         mask_m_c = 32'h0;
         cnt_m_c  = 0;
      end else begin
         if (c_out_valid && c_out_ready) begin
            n_cmp++;
            cnt_m_c++;
            if (q_c.size() == 0) begin
               n_bad++;
               $display("FAIL sb_c_unexpected: got %h, required no output", c_out_data);
            end else begin
               exp_c = q_c.pop_front();
               $display("c xfer: data=%h expected=%h", c_out_data, exp_c);
               if (c_out_data !== exp_c) begin
                  n_bad++;
                  $display("FAIL sb_c_data: got %h, required %h", c_out_data, exp_c);
               end
            end
         end
         if (c_in_valid && c_in_ready) q_c.push_back(ref_f(c_in_mode, c_in_data, mask_m_c));
         if (c_mask_we) mask_m_c = c_mask_din;
      end
   end

   task automatic a_cycle(input logic iv, input logic [7:0] d, input logic [1:0] m,
                          input logic we, input logic [7:0] md, input logic ordy);
      @(posedge clk);
      #1;
      a_in_valid  = iv;
      a_in_data   = d;
      a_in_mode   = m;
      a_mask_we   = we;
      a_mask_din  = md;
      a_out_ready = ordy;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_in_ready !== 1'b0 || a_word_cnt !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_state: got valid=%b data=%h in_ready=%b cnt=%h, required 0 0 0 0",
                  a_out_valid, a_out_data, a_in_ready, a_word_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (a_in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready: got %b, required 1", a_in_ready);
      end
   endtask

   task automatic test_invert_latency();
      a_cycle(1'b1, 8'hA5, 2'b01, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (a_in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL inv_accept: got in_ready=%b, required 1", a_in_ready);
      end
      a_cycle(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (a_out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL inv_early: got out_valid=%b one cycle after accept, required 0", a_out_valid);
      end
      a_cycle(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'h5A) begin
         n_bad++;
         $display("FAIL inv_latency: got valid=%b data=%h, required 1 5a", a_out_valid, a_out_data);
      end
      a_cycle(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (a_word_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL inv_word_cnt: got %0d, required 1", a_word_cnt);
      end
   endtask

   task automatic test_mask();
      logic [7:0] got [8];
      logic [7:0] want [3];
      int         n;
      n = 0;
      want[0] = 8'hAA; want[1] = 8'h55; want[2] = 8'hAA;
      for (int c = 0; c < 9; c++) begin
         case (c)
            0:       a_cycle(1'b0, 8'h00, 2'b00, 1'b1, 8'h0F, 1'b1);
            1:       a_cycle(1'b1, 8'hA5, 2'b10, 1'b0, 8'h00, 1'b1);
            2:       a_cycle(1'b1, 8'hA5, 2'b11, 1'b0, 8'h00, 1'b1);
            3:       a_cycle(1'b1, 8'hA5, 2'b10, 1'b1, 8'hFF, 1'b1);
            default: a_cycle(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
         endcase
         if (a_out_valid && a_out_ready && n < 8) begin
            got[n] = a_out_data;
            n++;
         end
      end
      n_cmp++;
      if (n != 3) begin
         n_bad++;
         $display("FAIL mask_count: got %0d outputs, required 3", n);
      end
      for (int i = 0; i < 3 && i < n; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin
            n_bad++;
            $display("FAIL mask_result[%0d]: got %h, required %h", i, got[i], want[i]);
         end
      end
      n_cmp++;
      if (a_word_cnt !== 16'd4) begin
         n_bad++;
         $display("FAIL mask_word_cnt: got %0d, required 4", a_word_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] w [5];
      logic [7:0] got [8];
      int         cyc [8];
      int         idx;
      int         n;
      w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; w[3] = 8'h04; w[4] = 8'h00;
      idx = 0;
      n   = 0;
      for (int c = 0; c < 6; c++) begin
         a_cycle(idx < 4, w[idx], 2'b00, 1'b0, 8'h00, 1'b0);
         if (a_in_valid && a_in_ready) idx++;
         if (c >= 2) begin
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'h01) begin
               n_bad++;
               $display("FAIL bp_hold: got valid=%b data=%h, required 1 01", a_out_valid, a_out_data);
            end
         end
      end
      n_cmp++;
      if (idx != 2 || a_in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_full: got accepted=%0d in_ready=%b, required 2 0", idx, a_in_ready);
      end
      for (int c = 0; c < 12; c++) begin
         a_cycle(idx < 4, w[idx], 2'b00, 1'b0, 8'h00, 1'b1);
         if (a_in_valid && a_in_ready) idx++;
         if (a_out_valid && a_out_ready && n < 8) begin
            got[n] = a_out_data;
            cyc[n] = c;
            n++;
         end
      end
      n_cmp++;
      if (n != 4) begin
         n_bad++;
         $display("FAIL bp_count: got %0d outputs, required 4", n);
      end
      for (int i = 0; i < 4 && i < n; i++) begin
         n_cmp++;
         if (got[i] !== w[i] || cyc[i] != cyc[0] + i) begin
            n_bad++;
            $display("FAIL bp_order[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                     i, got[i], cyc[i], w[i], cyc[0] + i);
         end
      end
   endtask

   task automatic test_reset_flush();
      a_cycle(1'b1, 8'h11, 2'b00, 1'b0, 8'h00, 1'b0);
      a_cycle(1'b1, 8'h22, 2'b00, 1'b0, 8'h00, 1'b0);
      a_cycle(1'b1, 8'h33, 2'b00, 1'b0, 8'h00, 1'b0);
      n_cmp++;
      if (a_out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_pre: got out_valid=%b before reset, required 1", a_out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_async: got valid=%b in_ready=%b, required 0 0", a_out_valid, a_in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (a_in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_ready_in_reset: got %b, required 0", a_in_ready);
      end
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      a_in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         a_cycle(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
         n_cmp++;
         if (a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stale: got out_valid=%b data=%h, required 0", a_out_valid, a_out_data);
         end
      end
      n_cmp++;
      if (a_word_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL flush_word_cnt: got %0d, required 0", a_word_cnt);
      end
   endtask

   task automatic test_cnt_wrap();
      int sent;
      int got;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 40 && sent < 17; c++) begin
         @(posedge clk);
         #1;
         b_in_valid  = 1'b1;
         b_in_data   = sent[7:0];
         b_out_ready = 1'b1;
         @(negedge clk);
         if (b_in_ready) sent++;
         if (b_out_valid) got++;
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         b_in_valid = 1'b0;
         @(negedge clk);
         if (b_out_valid) got++;
      end
      n_cmp++;
      if (sent != 17 || got != 17) begin
         n_bad++;
         $display("FAIL wrap_xfers: got sent=%0d delivered=%0d, required 17 17", sent, got);
      end
      n_cmp++;
      if (b_word_cnt !== 4'd1) begin
         n_bad++;
         $display("FAIL wrap_word_cnt: got %0d, required 1", b_word_cnt);
      end
   endtask

   task automatic test_random();
      logic        prev_stall;
      logic [31:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = 32'h0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk);
         #1;
         c_in_valid  = ($urandom_range(0, 9) < 7);
         c_in_data   = $urandom;
         c_in_mode   = 2'($urandom_range(0, 3));
         c_mask_we   = ($urandom_range(0, 9) == 0);
         c_mask_din  = $urandom;
         c_out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (c_out_ready) begin
            n_cmp++;
            if (c_in_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL rnd_throughput: cycle %0d got in_ready=%b with out_ready=1, required 1", c, c_in_ready);
            end
         end
         if (prev_stall) begin
            n_cmp++;
            if (c_out_valid !== 1'b1 || c_out_data !== prev_data) begin
               n_bad++;
               $display("FAIL rnd_hold: cycle %0d got valid=%b data=%h, required 1 %h",
                        c, c_out_valid, c_out_data, prev_data);
            end
         end
         prev_stall = c_out_valid && !c_out_ready;
         prev_data  = c_out_data;
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         c_in_valid  = 1'b0;
         c_mask_we   = 1'b0;
         c_out_ready = 1'b1;
         @(negedge clk);
      end
      n_cmp++;
      if (q_c.size() != 0) begin
         n_bad++;
         $display("FAIL rnd_drain: got %0d words still expected, required 0", q_c.size());
      end
      n_cmp++;
      if (c_word_cnt !== 16'(cnt_m_c)) begin
         n_bad++;
         $display("FAIL rnd_word_cnt: got %0d, required %0d", c_word_cnt, cnt_m_c);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      a_in_valid = 1'b0; a_in_data = 8'h0; a_in_mode = 2'b00; a_mask_we = 1'b0; a_mask_din = 8'h0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = 8'h0; b_in_mode = 2'b00; b_mask_we = 1'b0; b_mask_din = 8'h0; b_out_ready = 1'b0;
      c_in_valid = 1'b0; c_in_data = 32'h0; c_in_mode = 2'b00; c_mask_we = 1'b0; c_mask_din = 32'h0; c_out_ready = 1'b0;
      test_reset();
      test_invert_latency();
      test_mask();
      test_backpressure();
      test_reset_flush();
      test_cnt_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
